alu_serial_lanes: RTL and testbench
===================================

# alu_serial_lanes

Parametrised multi-lane bit-serial ALU for the gclk-driven datapath. Each lane consumes one operand bit pair per accepted beat, LSB first, and produces one result bit per beat. Words are framed by start/end markers. Per-lane carry state is held across beats, and carry, overflow and zero flags are reported on the word's last bit. All lanes share one control word and one fixed-latency output pipeline.

## Interface
Parameters:
- LANES, 4, number of independent serial lanes sharing framing and opcode
- LAT, 5, beat-to-result latency in cycles; legal range 1..16

Ports:
- gclk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat present this cycle
- start  in  1  beat is bit 0 (LSB) of a word
- end  in  1  beat is the MSB of a word
- x  in  LANES  operand X bit, one per lane
- y  in  LANES  operand Y bit, one per lane
- cmpl_x  in  1  invert X bits for the whole word; sampled on start beat
- cmpl_y  in  1  invert Y bits for the whole word; sampled on start beat
- op  in  2  operation, sampled on start beat: 00 XOR, 01 AND, 10 ARITH, 11 OR
- carry_in  in  LANES  initial carry per lane; sampled on start beat
- out_valid  out  1  result beat present
- out_end  out  1  result beat is the word MSB; flags valid
- sum  out  LANES  result bit per lane
- carry_out  out  LANES  final carry; meaningful only when out_end
- overflow  out  LANES  signed overflow; meaningful only when out_end
- zero  out  LANES  all result bits of word were 0; meaningful only when out_end
- err  out  1  one-cycle protocol-error pulse, aligned with out_valid timing

## Operation
- FSM states: IDLE and IN_WORD.
  - IDLE + valid start: latch op, cmpl_x, cmpl_y; load carry[i] = carry_in[i]; set zacc[i] = 1. Go to IN_WORD, or stay in IDLE if end is also set (1-bit word).
  - IN_WORD + valid end: process the beat, then go to IDLE.
  - IN_WORD + valid start: abort the current word. Its partial beats already issued stand. Pulse err. Restart as for a start beat from IDLE.
  - IDLE + valid beat without start: drop the beat. No out_valid. Pulse err.
- Per lane and beat:
  - a = x^cmpl_x, b = y^cmpl_y, c = carry on the start beat (carry_in) or the stored carry otherwise.
  - ARITH: sum = a^b^c; next carry = maj(a,b,c); carry_out = next carry on the end beat; overflow = c ^ carry_out on the end beat.
  - XOR, AND, OR: sum = a^b, a&b, a|b respectively; carry register holds 0; carry_out = 0; overflow = 0.
  - zero = zacc & ~sum on the end beat. zacc clears on any 1 result bit.
- Beats with in_valid=0 are bubbles. All state holds, and a bubble is emitted with out_valid=0.
- Subtraction X−Y is ARITH with cmpl_y=1 and carry_in=1. carry_out=1 means no borrow.

## Timing
- Compute is one registered stage; a delay line then brings the total to exactly LAT cycles. A beat accepted at edge t appears on outputs during cycle t+LAT.
- Throughput is one beat per cycle, with no backpressure.
- Reset values:
  - FSM: IDLE
  - carry: 0; zacc: 1
  - All pipeline stages cleared
  - Outputs: out_valid=0, out_end=0, sum=0, carry_out=0, overflow=0, zero=0, err=0
- Reset mid-word: every in-flight beat is discarded. No partial-word flags are emitted. The first output after reset is the result of a beat accepted after reset is deasserted.
- Flags (carry_out, overflow, zero) are 0 whenever out_end=0.
- rst takes priority over every input in the same cycle.

## Test plan
- ADD, LANES=1, LAT=5: X=0011 and Y=0101 LSB first, start on beat 0, end on beat 3, carry_in=0. Expect sum bits 0,0,0,1 (1000) in cycles t+5..t+8, and on out_end: carry_out=0, overflow=1, zero=0.
- SUB: X=0101, Y=0011, cmpl_y=1, carry_in=1. Expect sum 0010, carry_out=1, overflow=0. Insert two bubbles between beats 1 and 2; expect identical results, with out_valid low for two cycles.
- Lane independence, LANES=4, AND with X=1111 on all lanes, Y = 0000/0001/1000/1111 per lane. Expect zero=1,0,0,0; carry_out=0 and overflow=0 on all lanes.
- 1-bit word (start=end=1), ARITH, x=y=1, carry_in=1. Expect sum=1, carry_out=1, overflow=0, out_end=1 in the same cycle as out_valid.
- Protocol errors:
  - Valid beat with no start while IDLE: beat dropped, err pulses at t+LAT.
  - Start two beats into a word: err pulses; the new word computes correctly from its own carry_in.
- Reset on beat 2 of a 4-bit word. Expect out_valid=0 for all prior in-flight beats. A following 0000+0000 word yields zero=1, carry_out=0.

Source files
------------

// File: rtl/alu_serial_lanes.sv
// alu_serial_lanes
//   Multi-lane bit-serial ALU. Each lane takes one X/Y bit pair per accepted
//   beat, LSB first, and returns one result bit per beat. All lanes share the
//   word framing (start/end), the opcode and the operand-complement controls.
//   A word's carry, overflow and zero flags are reported on its MSB beat.
//   The result leaves a single compute register followed by a delay line, so
//   the total latency is LAT register stages.
//
// Ports
//   gclk_i         clock, rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     beat present this cycle
//   start_i        beat is bit 0 of a word
//   end_i          beat is the MSB of a word
//   x_i, y_i       operand bits, one per lane
//   cmpl_x_i       invert X for the whole word (sampled on start)
//   cmpl_y_i       invert Y for the whole word (sampled on start)
//   op_i           00 XOR, 01 AND, 10 ARITH, 11 OR (sampled on start)
//   carry_in_i     initial carry per lane (sampled on start)
//   out_valid_o    result beat present
//   out_end_o      result beat is the word MSB; flags valid
//   sum_o          result bit per lane
//   carry_out_o    final carry per lane, only on out_end_o
//   overflow_o     signed overflow per lane, only on out_end_o
//   zero_o         word was all zeros per lane, only on out_end_o
//   err_o          one-cycle protocol error pulse, aligned with result timing
//
// FSM states
//   state     | meaning
//   S_IDLE    | between words, waiting for a start beat
//   S_IN_WORD | word in progress, carry/zero accumulators live

module alu_serial_lanes #(
  parameter int LANES = 4,
  parameter int LAT   = 5
) (
  input  logic             gclk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             start_i,
  input  logic             end_i,
  input  logic [LANES-1:0] x_i,
  input  logic [LANES-1:0] y_i,
  input  logic             cmpl_x_i,
  input  logic             cmpl_y_i,
  input  logic [1:0]       op_i,
  input  logic [LANES-1:0] carry_in_i,
  output logic             out_valid_o,
  output logic             out_end_o,
  output logic [LANES-1:0] sum_o,
  output logic [LANES-1:0] carry_out_o,
  output logic [LANES-1:0] overflow_o,
  output logic [LANES-1:0] zero_o,
  output logic             err_o
);

  typedef enum logic {S_IDLE, S_IN_WORD} state_t;

  localparam logic [1:0] OP_XOR   = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic             err;
    logic [LANES-1:0] sum;
    logic [LANES-1:0] cout;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] zero;
  } beat_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             cmpl_x_q, cmpl_x_d;
  logic             cmpl_y_q, cmpl_y_d;
  logic [LANES-1:0] carry_q, carry_d;
  logic [LANES-1:0] zacc_q, zacc_d;
  beat_t            pipe_q [LAT];
  beat_t            beat_d;

  logic             in_word;
  logic             accept;
  logic             proto_err;
  logic             is_arith;
  logic [1:0]       op_eff;
  logic             cx_eff;
  logic             cy_eff;
  logic [LANES-1:0] a;
  logic [LANES-1:0] b;
  logic [LANES-1:0] c;
  logic [LANES-1:0] zin;
  logic [LANES-1:0] res;
  logic [LANES-1:0] ncarry;

  always_comb begin
    in_word   = (state_q == S_IN_WORD);
    accept    = in_valid_i && (start_i || in_word);
    // Error when a start arrives inside a word, or a non-start beat arrives
    // while idle: both reduce to start matching the in-word flag.
    proto_err = in_valid_i && (start_i == in_word);

    // Start beats use the live controls; later beats use the latched copy.
    op_eff   = start_i ? op_i     : op_q;
    cx_eff   = start_i ? cmpl_x_i : cmpl_x_q;
    cy_eff   = start_i ? cmpl_y_i : cmpl_y_q;
    is_arith = (op_eff == OP_ARITH);

    a   = x_i ^ {LANES{cx_eff}};
    b   = y_i ^ {LANES{cy_eff}};
    c   = start_i ? carry_in_i : carry_q;
    zin = start_i ? {LANES{1'b1}} : zacc_q;

    case (op_eff)
      OP_XOR:   res = a ^ b;
      OP_AND:   res = a & b;
      OP_ARITH: res = a ^ b ^ c;
      default:  res = a | b;
    endcase

    ncarry = is_arith ? ((a & b) | (a & c) | (b & c)) : '0;

    state_d  = state_q;
    op_d     = op_q;
    cmpl_x_d = cmpl_x_q;
    cmpl_y_d = cmpl_y_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    beat_d   = '0;

    if (accept) begin
      state_d      = end_i ? S_IDLE : S_IN_WORD;
      op_d         = op_eff;
      cmpl_x_d     = cx_eff;
      cmpl_y_d     = cy_eff;
      carry_d      = ncarry;
      zacc_d       = zin & ~res;
      beat_d.valid = 1'b1;
      beat_d.last  = end_i;
      beat_d.sum   = res;
      if (end_i) begin
        beat_d.cout = ncarry;
        // c is the carry into the MSB; logic ops may see a non-zero
        // carry_in on a 1-bit word, so gate by opcode.
        beat_d.ovf  = is_arith ? (c ^ ncarry) : '0;
        beat_d.zero = zin & ~res;
      end
    end
    beat_d.err = proto_err;
  end

  always_ff @(posedge gclk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_XOR;
      cmpl_x_q <= 1'b0;
      cmpl_y_q <= 1'b0;
      carry_q  <= '0;
      zacc_q   <= '1;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cmpl_x_q  <= cmpl_x_d;
      cmpl_y_q  <= cmpl_y_d;
      carry_q   <= carry_d;
      zacc_q    <= zacc_d;
      pipe_q[0] <= beat_d;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_valid_o = pipe_q[LAT-1].valid;
  assign out_end_o   = pipe_q[LAT-1].last;
  assign sum_o       = pipe_q[LAT-1].sum;
  assign carry_out_o = pipe_q[LAT-1].cout;
  assign overflow_o  = pipe_q[LAT-1].ovf;
  assign zero_o      = pipe_q[LAT-1].zero;
  assign err_o       = pipe_q[LAT-1].err;

endmodule

// File: tb/tb_alu_serial_lanes.sv
// Directed bench for alu_serial_lanes (LANES=4, LAT=5). Every cycle is
// stepped from one initial block; outputs are logged 1ns after each rising
// edge, and a beat captured at log index k is expected at index k+L-1.

module tb_alu_serial_lanes;

  localparam int L = 5;
  localparam logic [1:0] XOR_OP = 2'b00;
  localparam logic [1:0] AND_OP = 2'b01;
  localparam logic [1:0] ADD_OP = 2'b10;

  logic       gclk;
  logic       rst;
  logic       vld, sop, eop;
  logic [3:0] x, y;
  logic       cx, cy;
  logic [1:0] op;
  logic [3:0] cin;
  logic       out_valid, out_end, err;
  logic [3:0] sum, carry_out, overflow, zero;

  logic       lg_v   [256];
  logic       lg_e   [256];
  logic       lg_err [256];
  logic [3:0] lg_s   [256];
  logic [3:0] lg_co  [256];
  logic [3:0] lg_ov  [256];
  logic [3:0] lg_z   [256];

  int cyc;
  int n_chk;
  int n_fail;

  alu_serial_lanes #(.LANES(4), .LAT(L)) dut (
    .gclk_i      (gclk),
    .rst_i       (rst),
    .in_valid_i  (vld),
    .start_i     (sop),
    .end_i       (eop),
    .x_i         (x),
    .y_i         (y),
    .cmpl_x_i    (cx),
    .cmpl_y_i    (cy),
    .op_i        (op),
    .carry_in_i  (cin),
    .out_valid_o (out_valid),
    .out_end_o   (out_end),
    .sum_o       (sum),
    .carry_out_o (carry_out),
    .overflow_o  (overflow),
    .zero_o      (zero),
    .err_o       (err)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic step(input logic v, input logic s, input logic e,
                      input logic [3:0] xv, input logic [3:0] yv,
                      input logic cxv, input logic cyv,
                      input logic [1:0] o, input logic [3:0] ci,
                      output int cap);
    vld = v; sop = s; eop = e; x = xv; y = yv;
    cx = cxv; cy = cyv; op = o; cin = ci;
    @(posedge gclk);
    #1;
    lg_v[cyc]   = out_valid;
    lg_e[cyc]   = out_end;
    lg_err[cyc] = err;
    lg_s[cyc]   = sum;
    lg_co[cyc]  = carry_out;
    lg_ov[cyc]  = overflow;
    lg_z[cyc]   = zero;
    cap = cyc;
    cyc++;
  endtask

  task automatic bubbles(input int n);
    int dummy;
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 4'h0, 0, 0, XOR_OP, 4'h0, dummy);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output logged at absolute index idx.
  task automatic chk_at(input string tag, input int idx,
                        input logic ev, input logic ee, input logic [3:0] es,
                        input logic [3:0] eco, input logic [3:0] eov,
                        input logic [3:0] ez, input logic eerr);
    chk($sformatf("%s.valid", tag), {3'b0, lg_v[idx]},   {3'b0, ev});
    chk($sformatf("%s.end",   tag), {3'b0, lg_e[idx]},   {3'b0, ee});
    chk($sformatf("%s.sum",   tag), lg_s[idx],           es);
    chk($sformatf("%s.cout",  tag), lg_co[idx],          eco);
    chk($sformatf("%s.ovf",   tag), lg_ov[idx],          eov);
    chk($sformatf("%s.zero",  tag), lg_z[idx],           ez);
    chk($sformatf("%s.err",   tag), {3'b0, lg_err[idx]}, {3'b0, eerr});
  endtask

  int c0, c1, c2, c3, b0, b1, k0, rr;

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bubbles(3);
    chk_at("reset", 2, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    rst = 1'b0;

    // ADD 0011 + 0101 = 1000, signed overflow
    step(1, 1, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'h0, c0);
    step(1, 0, 0, 4'hF, 4'h0, 0, 0, ADD_OP, 4'h0, c1);
    step(1, 0, 0, 4'h0, 4'hF, 0, 0, ADD_OP, 4'h0, c2);
    step(1, 0, 1, 4'h0, 4'h0, 0, 0, ADD_OP, 4'h0, c3);
    bubbles(L);
    chk_at("add.b0", c0 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("add.b1", c1 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("add.b2", c2 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("add.b3", c3 + L - 1, 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 0);
    chk_at("add.after", c3 + L, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

    // SUB 0101 - 0011 = 0010 with two bubbles; cmpl_y only driven on start
    step(1, 1, 0, 4'hF, 4'hF, 0, 1, ADD_OP, 4'hF, c0);
    step(1, 0, 0, 4'h0, 4'hF, 0, 0, XOR_OP, 4'h0, c1);
    step(0, 0, 0, 4'hF, 4'hF, 1, 1, AND_OP, 4'hF, b0);
    step(0, 0, 0, 4'hF, 4'hF, 1, 1, AND_OP, 4'hF, b1);
    step(1, 0, 0, 4'hF, 4'h0, 0, 0, XOR_OP, 4'h0, c2);
    step(1, 0, 1, 4'h0, 4'h0, 0, 0, XOR_OP, 4'h0, c3);
    bubbles(L);
    chk_at("sub.b0",   c0 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("sub.b1",   c1 + L - 1, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    chk_at("sub.bub0", b0 + L - 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("sub.bub1", b1 + L - 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("sub.b2",   c2 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("sub.b3",   c3 + L - 1, 1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 0);

    // AND, X=1111; lane Y = 0000/0001/1000/1111; carry_in must not leak
    step(1, 1, 0, 4'hF, 4'hA, 0, 0, AND_OP, 4'hF, c0);
    step(1, 0, 0, 4'hF, 4'h8, 0, 0, AND_OP, 4'hF, c1);
    step(1, 0, 0, 4'hF, 4'h8, 0, 0, AND_OP, 4'hF, c2);
    step(1, 0, 1, 4'hF, 4'hC, 0, 0, AND_OP, 4'hF, c3);
    bubbles(L);
    chk_at("and.b0", c0 + L - 1, 1, 0, 4'hA, 4'h0, 4'h0, 4'h0, 0);
    chk_at("and.b3", c3 + L - 1, 1, 1, 4'hC, 4'h0, 4'h0, 4'h1, 0);

    // 1-bit word: 1 + 1 + carry 1
    step(1, 1, 1, 4'hF, 4'hF, 0, 0, ADD_OP, 4'hF, c0);
    bubbles(L);
    chk_at("bit1", c0 + L - 1, 1, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0);

    // Stray beat while idle: dropped, err only
    step(1, 0, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'hF, c0);
    bubbles(L);
    chk_at("stray", c0 + L - 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);

    // Start two beats into a word: old word leaves carry 1, new word uses 0
    step(1, 1, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'hF, c0);
    step(1, 0, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'h0, c1);
    step(1, 1, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'h0, c2);
    step(1, 0, 1, 4'h0, 4'h0, 0, 0, ADD_OP, 4'h0, c3);
    bubbles(L);
    chk_at("abort.o0", c0 + L - 1, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    chk_at("abort.o1", c1 + L - 1, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    chk_at("abort.n0", c2 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    chk_at("abort.n1", c3 + L - 1, 1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 0);

    // Reset on beat 2 of a 4-bit word, with the beat still presented
    step(1, 1, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'h0, c0);
    step(1, 0, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'h0, c1);
    rst = 1'b1;
    step(1, 0, 0, 4'hF, 4'hF, 0, 0, ADD_OP, 4'h0, rr);
    rst = 1'b0;
    k0 = 0;
    for (int k = 0; k < L - 1; k++) begin
      step(0, 0, 0, 4'h0, 4'h0, 0, 0, XOR_OP, 4'h0, k0);
    end
    for (int k = 0; k < L; k++) begin
      chk_at($sformatf("rst.flush%0d", k), rr + k, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    end

    // 0000 + 0000 after reset: clean start, zero on every lane
    step(1, 1, 0, 4'h0, 4'h0, 0, 0, ADD_OP, 4'h0, c0);
    step(1, 0, 0, 4'h0, 4'h0, 0, 0, ADD_OP, 4'h0, c1);
    step(1, 0, 0, 4'h0, 4'h0, 0, 0, ADD_OP, 4'h0, c2);
    step(1, 0, 1, 4'h0, 4'h0, 0, 0, ADD_OP, 4'h0, c3);
    bubbles(L + 1);
    chk_at("post.b0", c0 + L - 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    chk_at("post.b3", c3 + L - 1, 1, 1, 4'h0, 4'h0, 4'h0, 4'hF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
